uart_tx_unit: RTL and testbench

- Transmit end of the CPU's MMIO UART path.
- Accepts bytes from the CPU core via a write strobe plus `full` flag, buffers them in a small FIFO, and serialises each byte onto the `txd` pin as an 8N1 frame, LSB first.
- Sits between the core's `uart_tx_data`/`uart_wr_en`/`full` signals and the board TX pin.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_tx_unit.sv | 154 +++++++++++++++
 tb/tb_uart_tx_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding and line levels.
// Used by uart_tx_unit and the planned uart_rx_unit.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int   UART_DATA_BITS   = 8;
   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a head-of-queue read port.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_count_next;

   // Qualifiers use the registered flags, so a push while full is dropped even if a pop frees a slot.
   assign w_push = wr_en && !r_full;
   assign w_pop  = rd_en && !r_empty;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(DEPTH));
         r_empty <= (w_count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   assign rdata = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser (LSB first, idle-high line).
// Define UART_TX_PARITY_EN to insert an even-parity bit, giving 8E1 frames.
module uart_tx_unit
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] uart_tx_data,
   input  logic       uart_wr_en,
   output logic       full,
   output logic       txd,
   output logic       busy
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        IDX_LAST  = 3'(UART_DATA_BITS - 1);

   tx_state_t         r_state;
   tx_state_t         w_state_next;
   logic [BAUD_W-1:0] r_baud;
   logic [BAUD_W-1:0] w_baud_next;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_next;
   logic [7:0]        r_sh;
   logic [7:0]        w_sh_next;
   logic              r_txd;
   logic              w_txd_next;
   logic              r_busy;
   logic              w_busy_next;
   logic              w_pop;
   logic              w_baud_last;

   logic [7:0]        w_fifo_rdata;
   logic [CNT_W-1:0]  w_fifo_count;
   logic              w_fifo_full;
   logic              w_fifo_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .wr_en (uart_wr_en),
      .wdata (uart_tx_data),
      .rd_en (w_pop),
      .rdata (w_fifo_rdata),
      .count (w_fifo_count),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   assign w_baud_last = (r_baud == BAUD_LAST);

   // txd is registered from the current state, so the line lags the FSM by one cycle.
   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_idx_next   = r_idx;
      w_sh_next    = r_sh;
      w_pop        = 1'b0;
      w_txd_next   = UART_IDLE_LEVEL;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_sh_next    = w_fifo_rdata;
               w_baud_next  = '0;
               w_idx_next   = '0;
               w_state_next = START;
            end
         end
         START: begin
            w_txd_next = UART_START_LEVEL;
            if (w_baud_last) begin
               w_baud_next  = '0;
               w_idx_next   = '0;
               w_state_next = DATA;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         DATA: begin
            w_txd_next = r_sh[r_idx];
            if (w_baud_last) begin
               w_baud_next = '0;
               if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = PARITY;
`else
                  w_state_next = STOP;
`endif
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            w_txd_next = ^r_sh;
            if (w_baud_last) begin
               w_baud_next  = '0;
               w_state_next = STOP;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
`endif
         STOP: begin
            w_txd_next = UART_IDLE_LEVEL;
            if (w_baud_last) begin
               w_baud_next  = '0;
               w_state_next = IDLE;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      w_busy_next = (r_state != IDLE) || (w_fifo_count != '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_sh    <= '0;
         r_txd   <= UART_IDLE_LEVEL;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_idx   <= w_idx_next;
         r_sh    <= w_sh_next;
         r_txd   <= w_txd_next;
         r_busy  <= w_busy_next;
      end
   end

   assign txd  = r_txd;
   assign busy = r_busy;
   assign full = w_fifo_full;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Single-frame vectors come from a table; multi-frame corner cases are hand-written sequences.
module tb_uart_tx_unit;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] uart_tx_data;
   logic       uart_wr_en;
   logic       full;
   logic       txd;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_unit #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .uart_tx_data (uart_tx_data),
      .uart_wr_en   (uart_wr_en),
      .full         (full),
      .txd          (txd),
      .busy         (busy)
   );

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit 0 goes on the line first
   } vec_t;

   vec_t       vecs [4];
   logic [9:0] fill_frames [5];
   logic [9:0] busy_frames [5];
   logic [9:0] simul_frames [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      uart_tx_data = b;
      uart_wr_en   = 1'b1;
      @(posedge clk);
      #1;
      uart_wr_en = 1'b0;
   endtask

   task automatic expect_frame(input string name, input logic [10:0] bits, input int nbits);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < CPB; c++) begin
            step();
            chk($sformatf("%s bit%0d cyc%0d txd", name, b, c), 32'(txd), 32'(bits[b]));
         end
      end
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      int lows;
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (txd !== 1'b1) lows++;
      end
      chk(name, 32'(lows), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
      vecs[1] = '{data: 8'h3C, frame: 10'b1001111000};
      vecs[2] = '{data: 8'h81, frame: 10'b1100000010};
      vecs[3] = '{data: 8'h5A, frame: 10'b1010110100};
      fill_frames  = '{10'b1000000010, 10'b1000000100, 10'b1000000110,
                       10'b1000001000, 10'b1000001010};
      busy_frames  = '{10'b1000100010, 10'b1001000010, 10'b1001000100,
                       10'b1001000110, 10'b1001001000};
      simul_frames = '{10'b1010110100, 10'b1110000110, 10'b1100101100, 10'b1001111000};

      rstn         = 1'b0;
      uart_wr_en   = 1'b0;
      uart_tx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset txd", 32'(txd), 32'd1);
      chk("reset full", 32'(full), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) step();

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones, so even parity is 1; 11 bits * 4 = 44 cycles
      write_byte(8'h07);
      step();
      chk("par pre txd", 32'(txd), 32'd1);
      expect_frame("par 07", 11'b11000001110, 11);
      chk("par busy_last", 32'(busy), 32'd1);
      step();
      chk("par busy_end", 32'(busy), 32'd0);
      repeat (5) step();
`else
      // Table of single frames: start low 2 cycles after the write edge
      for (int i = 0; i < 4; i++) begin
         write_byte(vecs[i].data);
         chk($sformatf("vec%0d busy_at_write", i), 32'(busy), 32'd0);
         step();
         chk($sformatf("vec%0d pre txd", i), 32'(txd), 32'd1);
         chk($sformatf("vec%0d pre busy", i), 32'(busy), 32'd1);
         expect_frame($sformatf("vec%0d", i), {1'b0, vecs[i].frame}, 10);
         chk($sformatf("vec%0d busy_last", i), 32'(busy), 32'd1);
         step();
         chk($sformatf("vec%0d busy_end", i), 32'(busy), 32'd0);
         chk($sformatf("vec%0d txd_end", i), 32'(txd), 32'd1);
         chk($sformatf("vec%0d full_end", i), 32'(full), 32'd0);
         repeat (3) step();
      end

      // Five writes into an idle unit: the first pops early, all five reach the line
      fork
         begin
            write_byte(8'h01);
            write_byte(8'h02);
            write_byte(8'h03);
            write_byte(8'h04);
            chk("fill_idle full_after4", 32'(full), 32'd0);
            write_byte(8'h05);
         end
         begin
            step();
            step();
            chk("fill_idle pre txd", 32'(txd), 32'd1);
            for (int k = 0; k < 5; k++) begin
               expect_frame($sformatf("fill_idle f%0d", k), {1'b0, fill_frames[k]}, 10);
               step();
               chk($sformatf("fill_idle gap%0d", k), 32'(txd), 32'd1);
            end
         end
      join
      chk("fill_idle busy_end", 32'(busy), 32'd0);
      repeat (5) step();

      // Serialiser busy: four writes fill the FIFO, the fifth is dropped
      write_byte(8'h11);
      fork
         begin
            step();
            step();
            write_byte(8'h21);
            write_byte(8'h22);
            write_byte(8'h23);
            write_byte(8'h24);
            chk("fill_busy full_after4", 32'(full), 32'd1);
            write_byte(8'h25);
            chk("fill_busy full_after5", 32'(full), 32'd1);
         end
         begin
            step();
            chk("fill_busy pre txd", 32'(txd), 32'd1);
            for (int k = 0; k < 5; k++) begin
               expect_frame($sformatf("fill_busy f%0d", k), {1'b0, busy_frames[k]}, 10);
               step();
               chk($sformatf("fill_busy gap%0d", k), 32'(txd), 32'd1);
            end
         end
      join
      expect_quiet("fill_busy no_extra_frame", 60);
      chk("fill_busy busy_end", 32'(busy), 32'd0);
      chk("fill_busy full_end", 32'(full), 32'd0);
      repeat (5) step();

      // Push on the same edge the serialiser pops with two entries queued
      fork
         begin
            write_byte(8'h5A);
            write_byte(8'hC3);
            write_byte(8'h96);
            repeat (39) step();
            write_byte(8'h3C);
            chk("simul count", 32'(dut.u_fifo.count), 32'd2);
            chk("simul full", 32'(full), 32'd0);
         end
         begin
            step();
            step();
            chk("simul pre txd", 32'(txd), 32'd1);
            for (int k = 0; k < 4; k++) begin
               expect_frame($sformatf("simul f%0d", k), {1'b0, simul_frames[k]}, 10);
               step();
               chk($sformatf("simul gap%0d", k), 32'(txd), 32'd1);
            end
         end
      join
      repeat (5) step();

      // Back-to-back 0x00 then 0xFF: one idle-high cycle between frames, 81 cycles total
      fork
         begin
            write_byte(8'h00);
            write_byte(8'hFF);
         end
         begin
            step();
            step();
            chk("b2b pre txd", 32'(txd), 32'd1);
            expect_frame("b2b f0", 11'b01000000000, 10);
            step();
            chk("b2b gap", 32'(txd), 32'd1);
            expect_frame("b2b f1", 11'b01111111110, 10);
            chk("b2b busy_last", 32'(busy), 32'd1);
            step();
            chk("b2b busy_end", 32'(busy), 32'd0);
            chk("b2b txd_end", 32'(txd), 32'd1);
         end
      join
      repeat (5) step();
`endif

      // Asynchronous reset during data bit 3 of 0xA5 (bit 3 is 0, so the line is low)
      write_byte(8'hA5);
      repeat (19) step();
      chk("rst_mid txd_before", 32'(txd), 32'd0);
      #3;
      rstn = 1'b0;
      #1;
      chk("rst_mid txd", 32'(txd), 32'd1);
      chk("rst_mid full", 32'(full), 32'd0);
      chk("rst_mid busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      expect_quiet("rst_mid no_residual", 60);
      chk("rst_mid busy_after", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
